// File: rtl/ss_serializer.sv
// ss_serializer: parallel-to-serial stage feeding the serial sequence detector.
// Accepts a code word on a valid/ready handshake and shifts it out MSB-first, with an optional idle gap.
module ss_serializer #(
    parameter int   WIDTH      = 8,
    parameter int   GAP        = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int              CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LOAD  = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [3:0]      GAP_LOAD  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [WIDTH-1:0] SH_ZERO  = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_gcnt;
    logic             r_out;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_word_done;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [3:0]       w_gcnt_nxt;
    logic             w_load_ready;
    logic             w_handshake;
    logic             w_out_nxt;
    logic             w_out_valid_nxt;
    logic             w_busy_nxt;
    logic             w_word_done_nxt;

    // Ready is decoded from state and counter only; it must never look at load_valid.
    always_comb begin
        w_load_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load_ready = 1'b1;
            end
            ST_SHIFT: begin
                if ((GAP == 0) && (r_cnt == CNT_ZERO)) begin
                    w_load_ready = 1'b1;
                end else begin
                    w_load_ready = 1'b0;
                end
            end
            default: begin
                w_load_ready = 1'b0;
            end
        endcase
    end

    assign w_handshake = load_valid & w_load_ready;

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_gcnt_nxt  = r_gcnt;
        case (r_state)
            ST_IDLE: begin
                if (w_handshake) begin
                    w_state_nxt = ST_SHIFT;
                    w_shreg_nxt = data_in;
                    w_cnt_nxt   = CNT_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
                if (r_cnt != CNT_ZERO) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else if (GAP > 0) begin
                    w_state_nxt = ST_GAP;
                    w_gcnt_nxt  = GAP_LOAD;
                end else if (w_handshake) begin
                    // Back-to-back reload: next MSB follows this LSB without a bubble.
                    w_state_nxt = ST_SHIFT;
                    w_shreg_nxt = data_in;
                    w_cnt_nxt   = CNT_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_gcnt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gcnt_nxt = r_gcnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_shreg_nxt = SH_ZERO;
                w_cnt_nxt   = CNT_ZERO;
                w_gcnt_nxt  = 4'd0;
            end
        endcase
    end

    // Output decode from the next state so every output can be registered.
    always_comb begin
        w_out_nxt       = IDLE_LEVEL;
        w_out_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        w_word_done_nxt = 1'b0;
        case (w_state_nxt)
            ST_SHIFT: begin
                w_out_nxt       = w_shreg_nxt[WIDTH-1];
                w_out_valid_nxt = 1'b1;
                w_busy_nxt      = 1'b1;
                w_word_done_nxt = (w_cnt_nxt == CNT_ZERO);
            end
            ST_GAP: begin
                w_busy_nxt = 1'b1;
            end
            default: begin
                w_out_nxt = IDLE_LEVEL;
            end
        endcase
    end

    // State register and datapath.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_shreg <= SH_ZERO;
            r_cnt   <= CNT_ZERO;
            r_gcnt  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gcnt  <= w_gcnt_nxt;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out       <= IDLE_LEVEL;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_word_done <= w_word_done_nxt;
        end
    end

    assign load_ready = w_load_ready;
    assign out        = r_out;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign word_done  = r_word_done;

endmodule

// File: tb/tb_ss_serializer.sv
// Scoreboard bench for ss_serializer: three instances (GAP=0, GAP=2, IDLE_LEVEL=1 with GAP=1).
module tb_ss_serializer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       a_rst, a_lv, a_lr, a_out, a_ov, a_busy, a_wd;
    logic [3:0] a_din;
    logic       b_rst, b_lv, b_lr, b_out, b_ov, b_busy, b_wd;
    logic [3:0] b_din;
    logic       c_rst, c_lv, c_lr, c_out, c_ov, c_busy, c_wd;
    logic [3:0] c_din;

    logic [1:0] q_a[$];
    logic [1:0] q_b[$];
    logic [1:0] q_c[$];

    int n_pass  = 0;
    int n_total = 0;

    ss_serializer #(.WIDTH(4), .GAP(0), .IDLE_LEVEL(1'b0)) u_a (
        .clock(clock), .reset(a_rst), .data_in(a_din), .load_valid(a_lv), .load_ready(a_lr),
        .out(a_out), .out_valid(a_ov), .busy(a_busy), .word_done(a_wd));

    ss_serializer #(.WIDTH(4), .GAP(2), .IDLE_LEVEL(1'b0)) u_b (
        .clock(clock), .reset(b_rst), .data_in(b_din), .load_valid(b_lv), .load_ready(b_lr),
        .out(b_out), .out_valid(b_ov), .busy(b_busy), .word_done(b_wd));

    ss_serializer #(.WIDTH(4), .GAP(1), .IDLE_LEVEL(1'b1)) u_c (
        .clock(clock), .reset(c_rst), .data_in(c_din), .load_valid(c_lv), .load_ready(c_lr),
        .out(c_out), .out_valid(c_ov), .busy(c_busy), .word_done(c_wd));

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // push one word MSB-first; word_done expected on the last bit
    task automatic push_word(input int which, input logic [3:0] w);
        for (int i = 3; i >= 0; i--) begin
            if (which == 0) q_a.push_back({w[i], (i == 0) ? 1'b1 : 1'b0});
            else if (which == 1) q_b.push_back({w[i], (i == 0) ? 1'b1 : 1'b0});
            else q_c.push_back({w[i], (i == 0) ? 1'b1 : 1'b0});
        end
    endtask

    always @(negedge clock) begin : mon_a
        logic [1:0] e;
        if (a_ov === 1'b1) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_bit", {3'b000, a_ov}, 4'd0);
            end else begin
                e = q_a.pop_front();
                chk("a_bit", {3'b000, a_out}, {3'b000, e[1]});
                chk("a_word_done", {3'b000, a_wd}, {3'b000, e[0]});
            end
        end else begin
            chk("a_wd_outside_word", {3'b000, a_wd}, 4'd0);
        end
    end

    always @(negedge clock) begin : mon_b
        logic [1:0] e;
        if (b_ov === 1'b1) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_bit", {3'b000, b_ov}, 4'd0);
            end else begin
                e = q_b.pop_front();
                chk("b_bit", {3'b000, b_out}, {3'b000, e[1]});
                chk("b_word_done", {3'b000, b_wd}, {3'b000, e[0]});
            end
        end else begin
            chk("b_wd_outside_word", {3'b000, b_wd}, 4'd0);
        end
    end

    always @(negedge clock) begin : mon_c
        logic [1:0] e;
        if (c_ov === 1'b1) begin
            if (q_c.size() == 0) begin
                chk("c_unexpected_bit", {3'b000, c_ov}, 4'd0);
            end else begin
                e = q_c.pop_front();
                chk("c_bit", {3'b000, c_out}, {3'b000, e[1]});
                chk("c_word_done", {3'b000, c_wd}, {3'b000, e[0]});
            end
        end else begin
            chk("c_wd_outside_word", {3'b000, c_wd}, 4'd0);
        end
    end

    initial begin
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        a_lv = 1'b0; b_lv = 1'b0; c_lv = 1'b0;
        a_din = 4'd0; b_din = 4'd0; c_din = 4'd0;

        // reset state
        @(negedge clock);
        chk("rst_out", {3'b000, a_out}, 4'd0);
        chk("rst_out_valid", {3'b000, a_ov}, 4'd0);
        chk("rst_load_ready", {3'b000, a_lr}, 4'd1);
        chk("rst_busy", {3'b000, a_busy}, 4'd0);
        chk("c_rst_out_idle_level", {3'b000, c_out}, 4'd1);
        @(posedge clock);
        @(posedge clock); #1;
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        @(negedge clock);
        chk("idle_load_ready", {3'b000, a_lr}, 4'd1);
        chk("c_idle_out", {3'b000, c_out}, 4'd1);

        // single word 1011
        @(posedge clock); #1;
        push_word(0, 4'b1011);
        a_lv = 1'b1; a_din = 4'b1011;
        @(posedge clock); #1;
        a_lv = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        chk("single_idle_ov", {3'b000, a_ov}, 4'd0);
        chk("single_idle_busy", {3'b000, a_busy}, 4'd0);
        chk("single_idle_lr", {3'b000, a_lr}, 4'd1);

        // back-to-back 1011 then 0110, no bubble
        @(posedge clock); #1;
        push_word(0, 4'b1011);
        push_word(0, 4'b0110);
        a_lv = 1'b1; a_din = 4'b1011;
        @(posedge clock); #1;
        a_din = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("b2b_continuous_valid", {3'b000, a_ov}, 4'd1);
            if (i == 1) chk("b2b_midword_lr", {3'b000, a_lr}, 4'd0);
            if (i == 3) chk("b2b_lastbit_lr", {3'b000, a_lr}, 4'd1);
            @(posedge clock); #1;
            if (i == 3) a_lv = 1'b0;
        end
        @(negedge clock);
        chk("b2b_end_ov", {3'b000, a_ov}, 4'd0);

        // ignored input during SHIFT
        @(posedge clock); #1;
        push_word(0, 4'b1001);
        a_lv = 1'b1; a_din = 4'b1001;
        @(posedge clock); #1;
        a_din = 4'b0110;
        @(posedge clock); #1;
        a_din = 4'b1111;
        @(negedge clock);
        chk("ignored_lr", {3'b000, a_lr}, 4'd0);
        @(posedge clock); #1;
        a_din = 4'b0000;
        @(posedge clock); #1;
        a_lv = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("ignored_end_busy", {3'b000, a_busy}, 4'd0);

        // mid-word asynchronous reset
        @(posedge clock); #1;
        q_a.push_back(2'b10);
        q_a.push_back(2'b10);
        a_lv = 1'b1; a_din = 4'b1111;
        @(posedge clock); #1;
        a_lv = 1'b0;
        @(posedge clock);
        @(negedge clock); #2;
        a_rst = 1'b0;
        #1;
        chk("async_rst_out", {3'b000, a_out}, 4'd0);
        chk("async_rst_ov", {3'b000, a_ov}, 4'd0);
        chk("async_rst_busy", {3'b000, a_busy}, 4'd0);
        chk("async_rst_lr", {3'b000, a_lr}, 4'd1);
        chk("async_rst_wd", {3'b000, a_wd}, 4'd0);
        @(posedge clock); #1;
        a_rst = 1'b1;
        @(negedge clock);
        chk("post_rst_no_residual", {3'b000, a_ov}, 4'd0);
        @(posedge clock); #1;
        push_word(0, 4'b0001);
        a_lv = 1'b1; a_din = 4'b0001;
        @(posedge clock); #1;
        a_lv = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        chk("post_rst_idle", {3'b000, a_busy}, 4'd0);

        // GAP=2 with load_valid held throughout
        @(posedge clock); #1;
        push_word(1, 4'b1100);
        push_word(1, 4'b1010);
        b_lv = 1'b1; b_din = 4'b1100;
        @(posedge clock); #1;
        b_din = 4'b1010;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            if (i == 3) chk("gap_lastbit_lr", {3'b000, b_lr}, 4'd0);
            if (i == 4 || i == 5) begin
                chk("gap_ov", {3'b000, b_ov}, 4'd0);
                chk("gap_busy", {3'b000, b_busy}, 4'd1);
                chk("gap_lr", {3'b000, b_lr}, 4'd0);
            end
            if (i == 6) begin
                chk("gap_end_lr", {3'b000, b_lr}, 4'd1);
                chk("gap_end_busy", {3'b000, b_busy}, 4'd0);
            end
            @(posedge clock); #1;
            if (i == 6) b_lv = 1'b0;
        end
        repeat (7) @(posedge clock);
        @(negedge clock);
        chk("gap_final_busy", {3'b000, b_busy}, 4'd0);
        chk("gap_final_lr", {3'b000, b_lr}, 4'd1);

        // IDLE_LEVEL=1, GAP=1, word 0000
        @(posedge clock); #1;
        push_word(2, 4'b0000);
        c_lv = 1'b1; c_din = 4'b0000;
        @(posedge clock); #1;
        c_lv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (i == 4) begin
                chk("c_gap_out", {3'b000, c_out}, 4'd1);
                chk("c_gap_ov", {3'b000, c_ov}, 4'd0);
                chk("c_gap_busy", {3'b000, c_busy}, 4'd1);
            end
            if (i == 5) begin
                chk("c_idle_after_out", {3'b000, c_out}, 4'd1);
                chk("c_idle_after_busy", {3'b000, c_busy}, 4'd0);
                chk("c_idle_after_lr", {3'b000, c_lr}, 4'd1);
            end
            @(posedge clock);
        end

        repeat (2) @(posedge clock);
        #1;
        chk("a_queue_drained", 4'(q_a.size()), 4'd0);
        chk("b_queue_drained", 4'(q_b.size()), 4'd0);
        chk("c_queue_drained", 4'(q_c.size()), 4'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ss_serializer.md
Name: ss_serializer

Overview:
- Parallel-to-serial stage directly upstream of the serial sequence detector.
- Accepts a parallel code word through a valid/ready handshake and shifts it out MSB-first, one bit per clock.
- Its serial output drives the detector's `in` input.
- Provides framing status (out_valid, busy, word_done) and an optional idle gap between words so the detector sees well-defined bit streams.

Parameters:
- WIDTH, 8, code word width in bits (>=2).
- GAP, 0, idle cycles inserted after each word before the next load is accepted (0..15).
- IDLE_LEVEL, 0, level driven on out when no word is being shifted.

Ports:
- clock  input  1  single rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  WIDTH  parallel code word; sampled only on handshake.
- load_valid  input  1  upstream has a word on data_in.
- load_ready  output  1  block can accept a word this cycle.
- out  output  1  serial bit to detector `in`.
- out_valid  output  1  out carries a word bit this cycle.
- busy  output  1  word in flight (SHIFT or GAP state).
- word_done  output  1  one-cycle pulse coincident with the last bit of a word on out.

Behaviour:
- Reset (reset=0, asynchronous, overrides everything, including mid-word):
  - state=IDLE, shift register=0, bit counter=0.
  - out=IDLE_LEVEL, out_valid=0, load_ready=1, busy=0, word_done=0.
  - A partially shifted word is discarded.
  - Operation resumes on the first clock edge after reset=1.
- All outputs are registered. Combinational exception: load_ready is decoded from state/counter only and never depends on load_valid.
- States:
  - IDLE: load_ready=1, out=IDLE_LEVEL, out_valid=0, busy=0.
    - Handshake (load_valid & load_ready at an edge) latches data_in and goes to SHIFT. Counter is set to WIDTH-1.
    - With no handshake, stay in IDLE.
  - SHIFT: out=shreg[WIDTH-1], out_valid=1, busy=1.
    - Each edge shifts left by 1 with zero fill and decrements the counter.
    - At counter==0 (last bit on out), word_done=1.
    - Next state is GAP if GAP>0 (gap counter=GAP-1). If GAP==0, next state is IDLE, or SHIFT again if a handshake occurs on this cycle.
  - GAP: out=IDLE_LEVEL, out_valid=0, busy=1, load_ready=0.
    - Decrement the gap counter; go to IDLE when it reaches 0. The gap lasts exactly GAP cycles.
- Latency:
  - The first bit appears on out the cycle after the handshake edge.
  - A word occupies exactly WIDTH consecutive cycles of out_valid=1.
- Back-to-back, GAP==0: load_ready=1 during the last SHIFT cycle (counter==0). A handshake there makes the next word's MSB follow the previous LSB with no bubble, so out_valid stays 1 continuously.
- load_ready=0 during SHIFT cycles with counter>0 and during GAP. load_valid is ignored then; data_in changes have no effect.
- Counter width: $clog2(WIDTH). Gap counter: 4 bits. No wrap beyond the defined ranges.
- word_done never asserts outside SHIFT. It asserts exactly once per accepted word.

Test Plan:
- WIDTH=4, GAP=0. Reset low for 2 cycles, then high → out=0, out_valid=0, load_ready=1, busy=0. Pulse load_valid with data_in=4'b1011 → out 1,0,1,1 on the next 4 cycles with out_valid=1; word_done=1 on the 4th; then IDLE.
- WIDTH=4, GAP=0. Hold load_valid=1 with 4'b1011, then 4'b0110 presented during the last bit → out stream 1,0,1,1,0,1,1,0 with no bubble; word_done pulses on cycles 4 and 8.
- WIDTH=4, GAP=2. Load 4'b1100 → out 1,1,0,0, then 2 cycles with out_valid=0, busy=1, load_ready=0, then load_ready=1. A load_valid held throughout is accepted only at the first IDLE cycle.
- Mid-word reset: load 4'b1111 and assert reset=0 asynchronously after 2 bits (between edges) → outputs go to reset values immediately. After release there is no residual bit, and the next load 4'b0001 shifts 0,0,0,1.
- Ignored input: during SHIFT, drive load_valid=1 and toggle data_in → the serial stream is unchanged and no extra word_done occurs.
- IDLE_LEVEL=1 → out=1 in reset, IDLE and GAP; a word 4'b0000 shifts 0,0,0,0.
